// File: rtl/regspace_ahb2apb_bridge_if.sv
// Bus bundle for regspace_ahb2apb_bridge: AHB-Lite slave side (h_*) and APB master side (p_*).
// "slave" is the bridge's own view; "master" is the view of the surrounding AHB master and APB slave.
interface regspace_ahb2apb_bridge_if #(
    parameter int ADDR_W = 16
);
    logic              h_sel;
    logic [ADDR_W-1:0] h_addr;
    logic [1:0]        h_trans;
    logic              h_write;
    logic [2:0]        h_size;
    logic [3:0]        h_prot;
    logic [31:0]       h_wdata;
    logic              h_ready_in;
    logic              h_ready_out;
    logic              h_resp;
    logic [31:0]       h_rdata;

    logic [ADDR_W-1:0] p_addr;
    logic [2:0]        p_prot;
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [31:0]       p_wdata;
    logic [3:0]        p_strb;
    logic              p_ready;
    logic [31:0]       p_rdata;
    logic              p_slverr;

    modport slave (
        input  h_sel, h_addr, h_trans, h_write, h_size, h_prot, h_wdata, h_ready_in,
        output h_ready_out, h_resp, h_rdata,
        output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        input  p_ready, p_rdata, p_slverr
    );

    modport master (
        output h_sel, h_addr, h_trans, h_write, h_size, h_prot, h_wdata, h_ready_in,
        input  h_ready_out, h_resp, h_rdata,
        input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        output p_ready, p_rdata, p_slverr
    );
endinterface

// File: rtl/regspace_ahb2apb_bridge.sv
// AHB-Lite single-transfer slave to APB master bridge, one APB access outstanding at a time.
// Define REGSPACE_AHB2APB_TIMEOUT_EN to abandon an ACCESS phase after TIMEOUT_CYCLES without p_ready.
module regspace_ahb2apb_bridge #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                      clk,
    input logic                      rst_n,
    regspace_ahb2apb_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        legal;
    logic        timeout;
    logic [3:0]  strb;
    logic        h_ready_d, h_resp_d, p_sel_d, p_enable_d;

    assign accept = bus.h_sel && bus.h_trans[1] && bus.h_ready_in;

    always_comb begin
        legal = 1'b0;
        strb  = 4'b0000;
        unique case (bus.h_size)
            3'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << bus.h_addr[1:0];
            end
            3'd1: begin
                legal = ~bus.h_addr[0];
                strb  = 4'b0011 << bus.h_addr[1:0];
            end
            3'd2: begin
                legal = (bus.h_addr[1:0] == 2'b00);
                strb  = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                strb  = 4'b0000;
            end
        endcase
        if (!bus.h_write) strb = 4'b0000;
    end

`ifdef REGSPACE_AHB2APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    assign timeout = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive ACCESS cycles; zero on every entry into ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt <= '0;
        else if (state_q == ACCESS && state_d == ACCESS) wd_cnt <= wd_cnt + CNT_W'(1);
        else wd_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        h_ready_d  = 1'b0;
        h_resp_d   = 1'b0;
        p_sel_d    = 1'b0;
        p_enable_d = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR2: begin
                if (!accept)          state_d = IDLE;
                else if (!legal)      state_d = ERR1;
                else if (bus.h_write) state_d = WDATA;
                else                  state_d = SETUP;
            end
            WDATA:  state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (bus.p_ready)  state_d = bus.p_slverr ? ERR1 : DONE;
                else if (timeout) state_d = ERR1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered alongside it.
        unique case (state_d)
            IDLE, DONE: h_ready_d = 1'b1;
            ERR1:       h_resp_d  = 1'b1;
            ERR2: begin
                h_ready_d = 1'b1;
                h_resp_d  = 1'b1;
            end
            SETUP:      p_sel_d   = 1'b1;
            ACCESS: begin
                p_sel_d    = 1'b1;
                p_enable_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            bus.h_ready_out <= 1'b1;
            bus.h_resp      <= 1'b0;
            bus.h_rdata     <= '0;
            bus.p_sel       <= 1'b0;
            bus.p_enable    <= 1'b0;
            bus.p_write     <= 1'b0;
            bus.p_addr      <= '0;
            bus.p_wdata     <= '0;
            bus.p_strb      <= '0;
            bus.p_prot      <= '0;
        end else begin
            state_q         <= state_d;
            bus.h_ready_out <= h_ready_d;
            bus.h_resp      <= h_resp_d;
            bus.p_sel       <= p_sel_d;
            bus.p_enable    <= p_enable_d;

            if ((state_q == IDLE || state_q == DONE || state_q == ERR2) && accept && legal) begin
                bus.p_addr  <= {bus.h_addr[ADDR_W-1:2], 2'b00};
                bus.p_write <= bus.h_write;
                bus.p_strb  <= strb;
                bus.p_prot  <= {~bus.h_prot[0], 1'b1, bus.h_prot[1]};
            end

            if (state_q == WDATA) bus.p_wdata <= bus.h_wdata;

            // Read data is only meaningful on an OKAY read; anything else returns zero.
            if (state_q == ACCESS && bus.p_ready)
                bus.h_rdata <= (!bus.p_slverr && !bus.p_write) ? bus.p_rdata : 32'h0;
            else if (state_d == ERR1)
                bus.h_rdata <= 32'h0;
        end
    end
endmodule

// File: tb/tb_regspace_ahb2apb_bridge.sv
// Scoreboard bench for regspace_ahb2apb_bridge: pipelined AHB master, scripted APB slave,
// and a monitor comparing each AHB completion against a transfer-level reference model.
module tb_regspace_ahb2apb_bridge;
    localparam int ADDR_W         = 16;
    localparam int TIMEOUT_CYCLES = 8;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [15:0] addr;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic        err;
        int          waits;
        logic        chk_rdata;
        logic [31:0] rdata;
    } ahb_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  strb;
        logic        write;
        logic [2:0]  prot;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
    } apb_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regspace_ahb2apb_bridge_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.h_ready_in = bus.h_ready_out;

    regspace_ahb2apb_bridge #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    ahb_exp_t exp_q[$];
    apb_exp_t plan_q[$];
    int test_count = 0;
    int fail_count = 0;
    bit mon_en = 1'b0;
    bit apb_auto = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic is_legal(input logic [2:0] size, input logic [15:0] addr);
        int bytes;
        if (size > 3'd2) return 1'b0;
        bytes = 1 << size;
        return (int'(addr) % bytes) == 0;
    endfunction

    // Byte lanes touched by the transfer, from its byte count and starting lane.
    function automatic logic [3:0] exp_strb(input logic write, input logic [2:0] size, input logic [15:0] addr);
        int bytes, lane;
        logic [3:0] s;
        s = 4'h0;
        if (!write) return s;
        bytes = 1 << size;
        lane  = int'(addr) % 4;
        for (int b = 0; b < 4; b++)
            if (b >= lane && b < lane + bytes) s[b] = 1'b1;
        return s;
    endfunction

    function automatic txn_t mk(input logic sel, input logic [1:0] trans, input logic write,
                                input logic [2:0] size, input logic [15:0] addr, input logic [3:0] prot,
                                input logic [31:0] wdata, input int waits, input logic slverr,
                                input logic [31:0] rdata);
        txn_t t;
        t.sel = sel; t.trans = trans; t.write = write; t.size = size; t.addr = addr;
        t.prot = prot; t.wdata = wdata; t.waits = waits; t.slverr = slverr; t.rdata = rdata;
        return t;
    endfunction

    task automatic applyStimulus(input txn_t t);
        bit rdy;
        int guard;
        ahb_exp_t e;
        apb_exp_t p;
        bus.h_sel   = t.sel;
        bus.h_trans = t.trans;
        bus.h_write = t.write;
        bus.h_size  = t.size;
        bus.h_addr  = t.addr;
        bus.h_prot  = t.prot;
        guard = 0;
        do begin
            @(negedge clk);
            rdy = bus.h_ready_out;
            guard++;
            @(posedge clk);
            #1;
        end while (!rdy && guard < 5000);
        if (!rdy) begin
            checkOutput("ahb_accept_timeout", 32'd0, 32'd1);
            return;
        end
        bus.h_wdata = t.wdata;
        e.err = 1'b0; e.waits = 0; e.chk_rdata = 1'b0; e.rdata = 32'h0;
        if (t.sel && t.trans[1]) begin
            if (!is_legal(t.size, t.addr)) begin
                e.err   = 1'b1;
                e.waits = 1;
            end else begin
                e.err       = t.slverr;
                e.waits     = (t.write ? 3 : 2) + t.waits + (t.slverr ? 1 : 0);
                e.chk_rdata = 1'b1;
                e.rdata     = (!t.write && !t.slverr) ? t.rdata : 32'h0;
                p.addr   = 16'(int'(t.addr) / 4 * 4);
                p.strb   = exp_strb(t.write, t.size, t.addr);
                p.write  = t.write;
                p.prot   = {~t.prot[0], 1'b1, t.prot[1]};
                p.wdata  = t.wdata;
                p.waits  = t.waits;
                p.slverr = t.slverr;
                p.rdata  = t.rdata;
                plan_q.push_back(p);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drainIdle();
        int guard;
        bus.h_sel   = 1'b0;
        bus.h_trans = 2'd0;
        guard = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) checkOutput("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts wait states of the data phase in flight and checks its completion.
    initial begin
        int low_cnt;
        bit prev_rdy, prev_resp;
        ahb_exp_t e;
        low_cnt = 0; prev_rdy = 1'b1; prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && exp_q.size() != 0) begin
                if (!bus.h_ready_out) low_cnt++;
                else begin
                    e = exp_q.pop_front();
                    checkOutput("ahb_resp", 32'(bus.h_resp), 32'(e.err));
                    checkOutput("ahb_wait_states", low_cnt, e.waits);
                    if (e.chk_rdata) checkOutput("ahb_rdata", bus.h_rdata, e.rdata);
                    if (e.err) checkOutput("ahb_err_first_cycle", {prev_rdy, prev_resp}, 32'd1);
                    low_cnt = 0;
                end
            end else low_cnt = 0;
            prev_rdy  = bus.h_ready_out;
            prev_resp = bus.h_resp;
        end
    end

    // Scripted APB slave: checks each access against the plan and answers after its wait count.
    initial begin
        apb_exp_t p;
        int wleft;
        bit in_acc;
        wleft = 0; in_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (!apb_auto) begin
                in_acc = 1'b0;
                continue;
            end
            if (bus.p_sel && plan_q.size() == 0) begin
                checkOutput("apb_unexpected_psel", 32'(bus.p_sel), 32'd0);
                bus.p_ready = 1'b1;
                bus.p_slverr = 1'b0;
            end else if (bus.p_sel) begin
                p = plan_q[0];
                checkOutput("apb_addr", 32'(bus.p_addr), 32'(p.addr));
                checkOutput("apb_strb", 32'(bus.p_strb), 32'(p.strb));
                checkOutput("apb_write", 32'(bus.p_write), 32'(p.write));
                checkOutput("apb_prot", 32'(bus.p_prot), 32'(p.prot));
                if (p.write) checkOutput("apb_wdata", bus.p_wdata, p.wdata);
                if (bus.p_enable) begin
                    if (!in_acc) begin
                        in_acc = 1'b1;
                        wleft = p.waits;
                    end
                    if (wleft == 0) begin
                        bus.p_ready  = 1'b1;
                        bus.p_slverr = p.slverr;
                        bus.p_rdata  = p.rdata;
                        void'(plan_q.pop_front());
                        in_acc = 1'b0;
                    end else begin
                        bus.p_ready  = 1'b0;
                        bus.p_slverr = 1'($urandom);
                        bus.p_rdata  = $urandom;
                        wleft--;
                    end
                end else begin
                    bus.p_ready  = 1'($urandom);
                    bus.p_slverr = 1'($urandom);
                    bus.p_rdata  = $urandom;
                end
            end else begin
                bus.p_ready  = 1'($urandom);
                bus.p_slverr = 1'($urandom);
                bus.p_rdata  = $urandom;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        txn_t t;
        int acc_cycles;
        bit got_err;
        int guard;

        bus.h_sel = 1'b0; bus.h_addr = '0; bus.h_trans = 2'd0; bus.h_write = 1'b0;
        bus.h_size = 3'd0; bus.h_prot = 4'd0; bus.h_wdata = 32'h0;
        bus.p_ready = 1'b0; bus.p_rdata = 32'h0; bus.p_slverr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_h_ready_out", 32'(bus.h_ready_out), 32'd1);
        checkOutput("rst_h_resp", 32'(bus.h_resp), 32'd0);
        checkOutput("rst_h_rdata", bus.h_rdata, 32'h0);
        checkOutput("rst_p_sel", 32'(bus.p_sel), 32'd0);
        checkOutput("rst_p_enable", 32'(bus.p_enable), 32'd0);
        checkOutput("rst_p_write", 32'(bus.p_write), 32'd0);
        checkOutput("rst_p_addr", 32'(bus.p_addr), 32'd0);
        checkOutput("rst_p_wdata", bus.p_wdata, 32'h0);
        checkOutput("rst_p_strb", 32'(bus.p_strb), 32'd0);
        checkOutput("rst_p_prot", 32'(bus.p_prot), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        apb_auto = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(mk(1, 2'd2, 1, 3'd2, 16'h0010, 4'h1, 32'hA5A5_1234, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd2, 0, 3'd2, 16'h0020, 4'h2, 32'h0, 2, 0, 32'hDEAD_BEEF));
        applyStimulus(mk(1, 2'd2, 1, 3'd0, 16'h0005, 4'h3, 32'h1234_7F56, 1, 0, 32'h0));
        applyStimulus(mk(1, 2'd2, 0, 3'd1, 16'h0003, 4'h0, 32'h0, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd2, 0, 3'd2, 16'h0030, 4'h1, 32'h0, 0, 1, 32'h55AA_55AA));
        applyStimulus(mk(1, 2'd3, 1, 3'd1, 16'h0006, 4'h3, 32'hBEEF_0000, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd0, 1, 3'd2, 16'h0040, 4'h0, 32'h0, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd1, 0, 3'd2, 16'h0044, 4'h0, 32'h0, 0, 0, 32'h0));
        applyStimulus(mk(0, 2'd2, 1, 3'd2, 16'h0048, 4'h0, 32'h0, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd2, 1, 3'd3, 16'h0050, 4'h0, 32'h1111_2222, 0, 0, 32'h0));
        applyStimulus(mk(1, 2'd2, 1, 3'd2, 16'h0052, 4'h0, 32'h3333_4444, 0, 0, 32'h0));

        for (int i = 0; i < 300; i++) begin
            t.sel    = ($urandom_range(0, 9) != 0);
            t.trans  = ($urandom_range(0, 3) != 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            t.write  = 1'($urandom);
            t.size   = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            t.addr   = 16'($urandom);
            if ($urandom_range(0, 1) == 0) t.addr = 16'(int'(t.addr) / 4 * 4);
            t.prot   = 4'($urandom);
            t.wdata  = $urandom;
            t.waits  = $urandom_range(0, 3);
            t.slverr = ($urandom_range(0, 7) == 0);
            t.rdata  = $urandom;
            applyStimulus(t);
        end
        drainIdle();

        // Reset pulse in the middle of an APB ACCESS phase.
        mon_en = 1'b0;
        apb_auto = 1'b0;
        @(negedge clk);
        bus.p_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.h_sel = 1'b1; bus.h_trans = 2'd2; bus.h_write = 1'b0; bus.h_size = 3'd2; bus.h_addr = 16'h0040;
        @(posedge clk);
        #1;
        bus.h_sel = 1'b0; bus.h_trans = 2'd0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.p_enable && guard < 20);
        checkOutput("rstmid_in_access", 32'(bus.p_enable), 32'd1);
        checkOutput("rstmid_p_addr", 32'(bus.p_addr), 32'h0040);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_p_sel", 32'(bus.p_sel), 32'd0);
        checkOutput("rstmid_p_enable", 32'(bus.p_enable), 32'd0);
        checkOutput("rstmid_h_ready_out", 32'(bus.h_ready_out), 32'd1);
        checkOutput("rstmid_h_resp", 32'(bus.h_resp), 32'd0);
        checkOutput("rstmid_h_rdata", bus.h_rdata, 32'h0);
        checkOutput("rstmid_p_addr_clr", 32'(bus.p_addr), 32'd0);
        checkOutput("rstmid_p_wdata", bus.p_wdata, 32'h0);
        checkOutput("rstmid_p_strb", 32'(bus.p_strb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstmid_dropped_psel", 32'(bus.p_sel), 32'd0);
        checkOutput("rstmid_dropped_ready", 32'(bus.h_ready_out), 32'd1);

        // ACCESS with p_ready held low: watchdog abort or indefinite wait.
        @(posedge clk);
        #1;
        bus.h_sel = 1'b1; bus.h_trans = 2'd2; bus.h_write = 1'b0; bus.h_size = 3'd2; bus.h_addr = 16'h0080;
        @(posedge clk);
        #1;
        bus.h_sel = 1'b0; bus.h_trans = 2'd0;
        acc_cycles = 0;
        got_err = 1'b0;
        for (int i = 0; i < 1001; i++) begin
            @(negedge clk);
            if (bus.h_resp) begin
                got_err = 1'b1;
                break;
            end
            if (bus.p_enable) acc_cycles++;
        end
`ifdef REGSPACE_AHB2APB_TIMEOUT_EN
        checkOutput("timeout_err_seen", 32'(got_err), 32'd1);
        checkOutput("timeout_access_cycles", acc_cycles, TIMEOUT_CYCLES);
        checkOutput("timeout_err1_ready", 32'(bus.h_ready_out), 32'd0);
        checkOutput("timeout_psel_dropped", 32'(bus.p_sel), 32'd0);
        bus.p_ready = 1'b1;
        bus.p_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("timeout_err2", {bus.h_ready_out, bus.h_resp, bus.p_sel}, 32'd6);
        bus.p_ready = 1'b0;
        @(negedge clk);
        checkOutput("timeout_late_ready_ignored", {bus.h_ready_out, bus.h_resp, bus.p_sel}, 32'd4);
`else
        checkOutput("no_timeout_still_waiting", {got_err, bus.h_ready_out, bus.p_enable}, 32'd1);
        checkOutput("no_timeout_access_cycles", acc_cycles, 1000);
        bus.p_ready = 1'b1;
        bus.p_slverr = 1'b0;
        bus.p_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.p_ready = 1'b0;
        checkOutput("late_done_ready_resp", {bus.h_ready_out, bus.h_resp}, 32'd2);
        checkOutput("late_done_rdata", bus.h_rdata, 32'h1357_9BDF);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
